// File: rtl/hpc_tx_pkt_arbiter.sv
// Packet-granular round-robin arbiter for the shared 256-bit HPC TX AXIS link.
// The grant is locked for a whole packet, and the datapath is a zero-latency mux once granted.
module hpc_tx_pkt_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 256,
  parameter int KEEP_W  = 5,
  parameter int USER_W  = 7,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        iv_src_valid,
  input  logic [NUM_SRC-1:0]        iv_src_last,
  input  logic [NUM_SRC-1:0]        iv_src_start,
  input  logic [NUM_SRC*DATA_W-1:0] iv_src_data,
  input  logic [NUM_SRC*KEEP_W-1:0] iv_src_keep,
  input  logic [NUM_SRC*USER_W-1:0] iv_src_user,
  output logic [NUM_SRC-1:0]        ov_src_ready,
  output logic                      o_tx_valid,
  output logic                      o_tx_last,
  output logic                      o_tx_start,
  output logic [DATA_W-1:0]         ov_tx_data,
  output logic [KEEP_W-1:0]         ov_tx_keep,
  output logic [USER_W-1:0]         ov_tx_user,
  input  logic                      i_tx_ready,
  output logic [NUM_SRC-1:0]        ov_grant,
  output logic [NUM_SRC-1:0]        ov_proto_err,
  output logic [NUM_SRC*CNT_W-1:0]  ov_pkt_cnt
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic {IDLE, LOCK} state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [NUM_SRC-1:0] err_q, err_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               mid_q, mid_d;
  logic [CNT_W-1:0]   cnt_q [NUM_SRC];
  logic [CNT_W-1:0]   cnt_d [NUM_SRC];

  logic [NUM_SRC-1:0] req;
  logic [PTR_W-1:0]   gidx;
  logic [PTR_W-1:0]   pick;
  logic               found;
  logic               accept;

  assign req = iv_src_valid & iv_src_start;

  always_comb begin
    gidx = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant_q[i]) gidx = PTR_W'(i);
    end
  end

  // Scan starts one past the last-served source so the previous winner gets lowest priority.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx = (32'(ptr_q) + k) % NUM_SRC;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    mid_d        = mid_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    ov_src_ready = '0;
    o_tx_valid   = 1'b0;
    o_tx_last    = 1'b0;
    o_tx_start   = 1'b0;
    ov_tx_data   = '0;
    ov_tx_keep   = '0;
    ov_tx_user   = '0;
    accept       = 1'b0;
    case (state_q)
      IDLE: begin
        err_d = err_q | (iv_src_valid & ~iv_src_start);
        if (found) begin
          grant_d = NUM_SRC'(1) << pick;
          mid_d   = 1'b0;
          state_d = LOCK;
        end
      end
      LOCK: begin
        o_tx_valid   = iv_src_valid[gidx];
        o_tx_last    = iv_src_last[gidx];
        o_tx_start   = iv_src_start[gidx];
        ov_tx_data   = iv_src_data[32'(gidx)*DATA_W +: DATA_W];
        ov_tx_keep   = iv_src_keep[32'(gidx)*KEEP_W +: KEEP_W];
        ov_tx_user   = iv_src_user[32'(gidx)*USER_W +: USER_W];
        ov_src_ready = grant_q & {NUM_SRC{i_tx_ready}};
        accept       = o_tx_valid && i_tx_ready;
        // mid_q marks that at least one beat of this packet has gone out
        if (iv_src_valid[gidx] && iv_src_start[gidx] && mid_q) err_d[gidx] = 1'b1;
        if (accept) begin
          if (o_tx_last) begin
            state_d     = IDLE;
            grant_d     = '0;
            ptr_d       = gidx;
            cnt_d[gidx] = cnt_q[gidx] + CNT_W'(1);
          end else begin
            mid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      err_q   <= '0;
      ptr_q   <= PTR_W'(NUM_SRC - 1);
      mid_q   <= 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
      mid_q   <= mid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ov_grant     = grant_q;
  assign ov_proto_err = err_q;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_cnt
    assign ov_pkt_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end

endmodule

// File: tb/tb_hpc_tx_pkt_arbiter.sv
// Scoreboard bench for hpc_tx_pkt_arbiter: per-source expected beats and expected grant order
// are queued as stimulus is driven and popped as beats are accepted on the TX link.
module tb_hpc_tx_pkt_arbiter;

  localparam int N  = 4;
  localparam int DW = 256;
  localparam int KW = 5;
  localparam int UW = 7;
  localparam int CW = 16;

  logic            clk;
  logic            rst;
  logic [N-1:0]    iv_src_valid, iv_src_last, iv_src_start;
  logic [N*DW-1:0] iv_src_data;
  logic [N*KW-1:0] iv_src_keep;
  logic [N*UW-1:0] iv_src_user;
  logic [N-1:0]    ov_src_ready;
  logic            o_tx_valid, o_tx_last, o_tx_start;
  logic [DW-1:0]   ov_tx_data;
  logic [KW-1:0]   ov_tx_keep;
  logic [UW-1:0]   ov_tx_user;
  logic            i_tx_ready;
  logic [N-1:0]    ov_grant, ov_proto_err;
  logic [N*CW-1:0] ov_pkt_cnt;

  hpc_tx_pkt_arbiter #(.NUM_SRC(N), .DATA_W(DW), .KEEP_W(KW), .USER_W(UW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .iv_src_valid(iv_src_valid), .iv_src_last(iv_src_last), .iv_src_start(iv_src_start),
    .iv_src_data(iv_src_data), .iv_src_keep(iv_src_keep), .iv_src_user(iv_src_user),
    .ov_src_ready(ov_src_ready),
    .o_tx_valid(o_tx_valid), .o_tx_last(o_tx_last), .o_tx_start(o_tx_start),
    .ov_tx_data(ov_tx_data), .ov_tx_keep(ov_tx_keep), .ov_tx_user(ov_tx_user),
    .i_tx_ready(i_tx_ready), .ov_grant(ov_grant), .ov_proto_err(ov_proto_err),
    .ov_pkt_cnt(ov_pkt_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          start;
    logic          last;
  } beat_t;

  beat_t       exp_q [N][$];
  int unsigned exp_gnt_q[$];
  int          exp_cnt [N];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          prev_last_cyc = 0;
  logic        in_pkt = 1'b0, have_prev = 1'b0, bubble_chk = 1'b0, prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops expected beats on every accepted transfer.
  always @(negedge clk) begin
    if (rst) begin
      in_pkt = 1'b0; have_prev = 1'b0; prev_stall = 1'b0;
    end else begin
      int    g;
      beat_t b;
      check_eq("ready_vs_grant", ov_src_ready, i_tx_ready ? ov_grant : '0);
      if (prev_stall) check_eq("stall_data", ov_tx_data, prev_data);
      prev_stall = o_tx_valid && !i_tx_ready;
      prev_data  = ov_tx_data;
      if (o_tx_valid && i_tx_ready) begin
        g = 0;
        for (int i = 0; i < N; i++) if (ov_grant[i]) g = i;
        if (!in_pkt) begin
          if (exp_gnt_q.size() == 0) check_eq("grant_extra", ov_grant, '0);
          else check_eq("grant_order", ov_grant, N'(1) << exp_gnt_q.pop_front());
          if (bubble_chk && have_prev) check_eq("bubble_gap", cyc - prev_last_cyc, 2);
        end
        if (exp_q[g].size() == 0) check_eq("beat_extra", 1, 0);
        else begin
          b = exp_q[g].pop_front();
          check_eq("beat_data", ov_tx_data, b.data);
          check_eq("beat_ctrl", {ov_tx_keep, ov_tx_user, o_tx_start, o_tx_last},
                   {b.keep, b.user, b.start, b.last});
        end
        in_pkt = !o_tx_last;
        if (o_tx_last) begin
          have_prev     = 1'b1;
          prev_last_cyc = cyc;
        end
      end
    end
  end

  task automatic wait_acc(input int s);
    int n = 0;
    bit acc;
    do begin
      @(negedge clk);
      acc = ov_src_ready[s] && iv_src_valid[s];
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 500);
    if (!acc) check_eq("accept_timeout", 0, 1);
  endtask

  task automatic drive_beat(input int s, input int b, input int nb, input int seq, input bit bad_start);
    beat_t bt;
    bt.data  = {(DW/32){8'(s), 8'(seq), 16'(b)}};
    bt.keep  = KW'(b + s);
    bt.user  = UW'(seq);
    bt.start = (b == 0) || (bad_start && b == 1);
    bt.last  = (b == nb - 1);
    iv_src_valid[s] = 1'b1;
    iv_src_start[s] = bt.start;
    iv_src_last[s]  = bt.last;
    iv_src_data[s*DW +: DW] = bt.data;
    iv_src_keep[s*KW +: KW] = bt.keep;
    iv_src_user[s*UW +: UW] = bt.user;
    exp_q[s].push_back(bt);
  endtask

  task automatic src_send(input int s, input int nb, input int seq,
                          input int gap_at = -1, input int gap_len = 0, input bit bad_start = 0);
    for (int b = 0; b < nb; b++) begin
      if (b == gap_at) begin
        iv_src_valid[s] = 1'b0;
        repeat (gap_len) begin
          @(negedge clk);
          check_eq("gap_grant", ov_grant, N'(1) << s);
          check_eq("gap_valid", o_tx_valid, 0);
          @(posedge clk); #1;
        end
      end
      drive_beat(s, b, nb, seq, bad_start);
      wait_acc(s);
    end
    exp_cnt[s]++;
    iv_src_valid[s] = 1'b0;
    iv_src_start[s] = 1'b0;
    iv_src_last[s]  = 1'b0;
  endtask

  task automatic two_pkts(input int s);
    src_send(s, 1, 10 + s);
    src_send(s, 1, 20 + s);
  endtask

  task automatic check_cnts(input string tag);
    for (int s = 0; s < N; s++) check_eq(tag, ov_pkt_cnt[s*CW +: CW], CW'(exp_cnt[s]));
  endtask

  task automatic clear_inputs();
    iv_src_valid = '0; iv_src_last = '0; iv_src_start = '0;
    iv_src_data  = '0; iv_src_keep = '0; iv_src_user  = '0;
    i_tx_ready   = 1'b1;
    for (int s = 0; s < N; s++) begin
      exp_q[s].delete();
      exp_cnt[s] = 0;
    end
    exp_gnt_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_grant", ov_grant, '0);
    check_eq("rst_err", ov_proto_err, '0);
    check_eq("rst_cnt", ov_pkt_cnt, '0);
    check_eq("rst_valid", o_tx_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    do_reset();

    // single source, latency, 3-beat packet
    exp_gnt_q.push_back(2);
    fork
      src_send(2, 3, 1);
      begin
        @(negedge clk); check_eq("lat_idle", ov_grant, '0);
        @(negedge clk); check_eq("lat_grant", ov_grant, 4'b0100);
      end
    join
    repeat (2) @(posedge clk); #1;
    check_eq("t1_idle_grant", ov_grant, '0);
    check_cnts("t1_cnt");

    // all sources continuously requesting single-beat packets
    do_reset();
    for (int r = 0; r < 2; r++) for (int s = 0; s < N; s++) exp_gnt_q.push_back(s);
    bubble_chk = 1'b1;
    fork
      two_pkts(0); two_pkts(1); two_pkts(2); two_pkts(3);
    join
    bubble_chk = 1'b0;
    check_eq("t2_gnt_left", exp_gnt_q.size(), 0);
    check_cnts("t2_cnt");

    // backpressure on a 4-beat packet
    exp_gnt_q.push_back(1);
    fork
      src_send(1, 4, 3);
      begin
        bit [6:0] pat;
        int n = 0;
        pat = 7'b1011001;
        while (ov_grant != 4'b0010 && n < 50) begin @(negedge clk); n++; end
        check_eq("t3_grant", ov_grant, 4'b0010);
        @(posedge clk); #1;
        for (int j = 1; j < 7; j++) begin
          i_tx_ready = pat[j];
          @(posedge clk); #1;
        end
        i_tx_ready = 1'b1;
      end
    join
    check_cnts("t3_cnt");

    // source underrun while another source waits
    exp_gnt_q.push_back(0);
    exp_gnt_q.push_back(3);
    fork
      src_send(0, 4, 4, 2, 5);
      begin
        repeat (2) @(posedge clk); #1;
        src_send(3, 2, 5);
      end
    join
    check_cnts("t4_cnt");

    // protocol errors
    do_reset();
    iv_src_valid[3] = 1'b1;
    @(posedge clk); #1;
    iv_src_valid[3] = 1'b0;
    @(negedge clk);
    check_eq("t5_err_idle", ov_proto_err, 4'b1000);
    check_eq("t5_no_grant", ov_grant, '0);
    @(posedge clk); #1;
    exp_gnt_q.push_back(1);
    src_send(1, 3, 6, -1, 0, 1);
    check_eq("t5_err_restart", ov_proto_err, 4'b1010);

    // reset mid-packet
    do_reset();
    exp_gnt_q.push_back(2);
    drive_beat(2, 0, 4, 7, 0); wait_acc(2);
    drive_beat(2, 1, 4, 7, 0); wait_acc(2);
    drive_beat(2, 2, 4, 7, 0);
    rst = 1'b1;
    #1;
    check_eq("t6_valid", o_tx_valid, 0);
    check_eq("t6_grant", ov_grant, '0);
    check_eq("t6_ready", ov_src_ready, '0);
    check_eq("t6_data", ov_tx_data, '0);
    check_eq("t6_ctrl", {o_tx_start, o_tx_last, ov_tx_keep, ov_tx_user}, '0);
    check_eq("t6_cnt", ov_pkt_cnt, '0);
    clear_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int s = 0; s < N; s++) exp_gnt_q.push_back(s);
    fork
      src_send(0, 1, 8); src_send(1, 1, 8); src_send(2, 1, 8); src_send(3, 1, 8);
    join
    check_eq("t6_gnt_left", exp_gnt_q.size(), 0);
    check_cnts("t6_cnt_after");

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
